// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: registered ready/valid on both sides, order-preserving,
// with synchronous flush and a selectable active clock edge.
//
// state   | meaning
// EMPTY   | no entry held
// ONE     | main entry valid
// TWO     | main and skid entries valid, upstream stalled
module pipe_skid_reg #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter bit                 NEG_EDGE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign in_ready   = (r_state != S_TWO);
  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (reset || flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_main_nxt  = in_data;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end else if (w_in_xfer) begin
            w_skid_nxt  = in_data;
            w_state_nxt = S_TWO;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            w_main_nxt  = r_skid;
            w_state_nxt = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk) begin
        r_state <= w_state_nxt;
        r_main  <= w_main_nxt;
        r_skid  <= w_skid_nxt;
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
        r_main  <= w_main_nxt;
        r_skid  <= w_skid_nxt;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: one posedge instance and one negedge instance,
// observing {out_valid, in_ready, occupancy, out_data} as a packed 12-bit word.
module tb_pipe_skid_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic         in_ready, out_valid;
  logic [1:0]   occupancy;

  logic         n_reset, n_flush, n_in_valid, n_out_ready;
  logic [W-1:0] n_in_data, n_out_data;
  logic         n_in_ready, n_out_valid;
  logic [1:0]   n_occupancy;

  logic [11:0] obs, nobs;
  assign obs  = {out_valid, in_ready, occupancy, out_data};
  assign nobs = {n_out_valid, n_in_ready, n_occupancy, n_out_data};

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .NEG_EDGE(1'b0)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .NEG_EDGE(1'b1)) u_dut_neg (
    .clk(clk), .reset(n_reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_data(n_in_data), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_ready(n_out_ready),
    .occupancy(n_occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
    tick();
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL reset_state: got %h want %h", obs, {1'b0, 1'b1, 2'd0, RV}); end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL reset_idle: got %h want %h", obs, {1'b0, 1'b1, 2'd0, RV}); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'h11}) begin errors++; $display("FAIL stream_11: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'h11}); end
    in_data = 8'h22;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'h22}) begin errors++; $display("FAIL stream_22: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'h22}); end
    in_data = 8'h33;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'h33}) begin errors++; $display("FAIL stream_33: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'h33}); end
    in_valid = 1'b0;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, 8'h33}) begin errors++; $display("FAIL stream_drain: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 8'h33}); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'hA1}) begin errors++; $display("FAIL skid_a1: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'hA1}); end
    in_data = 8'hA2;
    tick();
    checks++; if (obs !== {1'b1, 1'b0, 2'd2, 8'hA1}) begin errors++; $display("FAIL skid_full: got %h want %h", obs, {1'b1, 1'b0, 2'd2, 8'hA1}); end
    in_data = 8'hA3;
    tick();
    checks++; if (obs !== {1'b1, 1'b0, 2'd2, 8'hA1}) begin errors++; $display("FAIL skid_stall: got %h want %h", obs, {1'b1, 1'b0, 2'd2, 8'hA1}); end
    out_ready = 1'b1;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'hA2}) begin errors++; $display("FAIL skid_a2: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'hA2}); end
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'hA3}) begin errors++; $display("FAIL skid_a3: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'hA3}); end
    in_valid = 1'b0;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, 8'hA3}) begin errors++; $display("FAIL skid_drain: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 8'hA3}); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB1;
    tick();
    in_data = 8'hB2;
    tick();
    checks++; if (obs !== {1'b1, 1'b0, 2'd2, 8'hB1}) begin errors++; $display("FAIL flush_pre: got %h want %h", obs, {1'b1, 1'b0, 2'd2, 8'hB1}); end
    flush = 1'b1; in_data = 8'hB3;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL flush_two: got %h want %h", obs, {1'b0, 1'b1, 2'd0, RV}); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL flush_no_b3: got %h want %h", obs, {1'b0, 1'b1, 2'd0, RV}); end
    // Flush in ONE with a live input transfer: the input must be squashed too.
    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    flush = 1'b1; in_data = 8'hB5;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL flush_one: got %h want %h", obs, {1'b0, 1'b1, 2'd0, RV}); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'hC1}) begin errors++; $display("FAIL rf_pre: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'hC1}); end
    reset = 1'b1; flush = 1'b1; in_data = 8'hC2;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL rf_empty: got %h want %h", obs, {1'b0, 1'b1, 2'd0, RV}); end
    reset = 1'b0; flush = 1'b0; in_data = 8'hC4;
    tick();
    checks++; if (obs !== {1'b1, 1'b1, 2'd1, 8'hC4}) begin errors++; $display("FAIL rf_c4: got %h want %h", obs, {1'b1, 1'b1, 2'd1, 8'hC4}); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (obs !== {1'b0, 1'b1, 2'd0, 8'hC4}) begin errors++; $display("FAIL rf_drain: got %h want %h", obs, {1'b0, 1'b1, 2'd0, 8'hC4}); end
  endtask

  task automatic test_negedge();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    @(negedge clk); #1;
    n_reset = 1'b1; n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = 8'h00; n_out_ready = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (nobs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL neg_reset: got %h want %h", nobs, {1'b0, 1'b1, 2'd0, RV}); end
    n_reset = 1'b0; n_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_in_data = vals[i];
      @(posedge clk); #1;
      if (i == 0) begin
        checks++; if (nobs !== {1'b0, 1'b1, 2'd0, RV}) begin errors++; $display("FAIL neg_rise_%0d: got %h want %h", i, nobs, {1'b0, 1'b1, 2'd0, RV}); end
      end else begin
        checks++; if (nobs !== {1'b1, 1'b1, 2'd1, vals[i-1]}) begin errors++; $display("FAIL neg_rise_%0d: got %h want %h", i, nobs, {1'b1, 1'b1, 2'd1, vals[i-1]}); end
      end
      @(negedge clk); #1;
      checks++; if (nobs !== {1'b1, 1'b1, 2'd1, vals[i]}) begin errors++; $display("FAIL neg_fall_%0d: got %h want %h", i, nobs, {1'b1, 1'b1, 2'd1, vals[i]}); end
    end
    n_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (nobs !== {1'b1, 1'b1, 2'd1, 8'h33}) begin errors++; $display("FAIL neg_rise_drain: got %h want %h", nobs, {1'b1, 1'b1, 2'd1, 8'h33}); end
    @(negedge clk); #1;
    checks++; if (nobs !== {1'b0, 1'b1, 2'd0, 8'h33}) begin errors++; $display("FAIL neg_drain: got %h want %h", nobs, {1'b0, 1'b1, 2'd0, 8'h33}); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_reset = 1'b1; n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_reset_flush();
    test_negedge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
